seq_core_ctrl: RTL and testbench



---
 rtl/seq_core_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seq_core_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_core_ctrl.sv
// seq_core_ctrl: multi-cycle fetch/decode/execute controller driving an external ROM and ALU.
// Define SEQ_CORE_CTRL_PERF_CNT_EN to add the saturating retired_cnt instruction counter.
module seq_core_ctrl #(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 4,
  parameter  int ADDR_W  = 8,
  localparam int RSEL_W  = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2*RSEL_W
) (
  input  logic               one_shot_clock,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [DATA_W-1:0]  sw_a,
  input  logic [DATA_W-1:0]  sw_b,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_sel,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  out_reg,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [2:0]         state,
  output logic               halted,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_LDA  = 4'h9;
  localparam logic [3:0] OP_LDB  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] ir;
  logic [3:0]         op;
  logic [RSEL_W-1:0]  rd, rs;
  logic               is_alu_op;
  logic [DATA_W-1:0]  regs [NREGS];
  logic [DATA_W-1:0]  rd_val, rs_val;
  logic [DATA_W-1:0]  result;
  logic [ADDR_W-1:0]  pc_next;

  assign op        = ir[INSTR_W-1 -: 4];
  assign rd        = ir[2*RSEL_W-1 -: RSEL_W];
  assign rs        = ir[RSEL_W-1:0];
  assign is_alu_op = ~op[3];
  assign rd_val    = regs[rd];
  assign rs_val    = regs[rs];

  assign rom_addr  = pc;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_data  = regs[dbg_sel];

  always_ff @(posedge one_shot_clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // run is only consulted at instruction boundaries, so dropping it never aborts one
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        if (op == OP_HALT) state_d = S_HALT;
        else if (run)      state_d = S_FETCH;
        else               state_d = S_IDLE;
      end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    case (op)
      OP_JMP:  pc_next = ADDR_W'({rd, rs});
      OP_JZ:   if (rd_val == '0) pc_next = ADDR_W'(rs_val);
      OP_HALT: pc_next = pc;
      default: ;
    endcase
  end

  // All commits read the pre-edge register file, so rd==rs sources the old value
  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      result    <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[RSEL_W'(i)] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_FETCH: ir <= rom_data;
        S_DECODE: begin
          if (is_alu_op) begin
            alu_a   <= rd_val;
            alu_b   <= rs_val;
            alu_sel <= op;
          end
        end
        S_EXECUTE: if (is_alu_op) result <= alu_result;
        S_WRITEBACK: begin
          pc <= pc_next;
          if (is_alu_op) begin
            regs[rd] <= result;
          end else begin
            case (op)
              OP_MOV: regs[rd] <= rs_val;
              OP_LDA: regs[rd] <= sw_a;
              OP_LDB: regs[rd] <= sw_b;
              OP_OUT: begin
                out_reg   <= rd_val;
                out_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
  always_ff @(posedge one_shot_clock) begin
    if (reset)
      retired_cnt <= '0;
    else if (state_q == S_WRITEBACK && retired_cnt != '1)
      retired_cnt <= retired_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_seq_core_ctrl.sv
// Self-checking bench for seq_core_ctrl: bench-side ROM/ALU plus an instruction-level reference model.
// Covers SEQ_CORE_CTRL_PERF_CNT_EN when that macro is defined.
module tb_seq_core_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [7:0] rom_addr, rom_data, sw_a, sw_b;
  logic [7:0] alu_a, alu_b, alu_result, out_reg, pc, dbg_data;
  logic [3:0] alu_sel;
  logic       out_valid, halted;
  logic [2:0] state;
  logic [1:0] dbg_sel;
`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  logic [7:0] rom [256];
  int total = 0;
  int bad   = 0;

  // instruction-level reference model
  logic [7:0] m_r [4];
  logic [7:0] m_pc, m_out;
  logic       m_ov, m_halt;
  int         m_ret;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << 1;
      4'd7: return a >> 1;
      default: return a;
    endcase
  endfunction

  assign rom_data   = rom[rom_addr];
  assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

  seq_core_ctrl dut (
    .one_shot_clock(clk),
    .reset(reset),
    .run(run),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sw_a(sw_a),
    .sw_b(sw_b),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_result(alu_result),
    .out_reg(out_reg),
    .out_valid(out_valid),
    .pc(pc),
    .state(state),
    .halted(halted),
    .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  task automatic fill_rom(input logic [7:0] v);
    for (int a = 0; a < 256; a++) rom[a] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_out = 8'h00; m_ov = 1'b0; m_halt = 1'b0; m_ret = 0;
  endtask

  task automatic model_step();
    logic [7:0] ins, a, b;
    logic [3:0] op;
    logic [1:0] rd, rs;
    ins = rom[m_pc];
    op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0];
    a = m_r[rd]; b = m_r[rs];
    m_ov = 1'b0;
    if (m_ret < 65535) m_ret++;
    if (op < 4'd8) m_r[rd] = alu_fn(op, a, b);
    else if (op == 4'h8) m_r[rd] = b;
    else if (op == 4'h9) m_r[rd] = sw_a;
    else if (op == 4'hA) m_r[rd] = sw_b;
    else if (op == 4'hB) begin m_out = a; m_ov = 1'b1; end
    if (op == 4'hC)      m_pc = {4'h0, ins[3:0]};
    else if (op == 4'hD) m_pc = (a == 8'h00) ? b : m_pc + 8'd1;
    else if (op == 4'hF) m_halt = 1'b1;
    else                 m_pc = m_pc + 8'd1;
  endtask

  task automatic do_reset(input logic run_after);
    @(negedge clk);
    reset = 1'b1; run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; run = run_after;
    model_reset();
  endtask

  task automatic start_run();
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL start state: got %0d want 1", state); end
  endtask

  // one instruction: 4 edges from FETCH to commit, checked against the model
  task automatic step_check(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL %s decode_state: got %0d want 2", tag, state); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL %s valid_low: got %b want 0", tag, out_valid); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (pc !== m_pc) begin bad++; $display("FAIL %s pc: got %0h want %0h", tag, pc, m_pc); end
    total++;
    if (state !== (m_halt ? 3'd5 : 3'd1)) begin bad++; $display("FAIL %s state: got %0d want %0d", tag, state, m_halt ? 5 : 1); end
    total++;
    if (halted !== m_halt) begin bad++; $display("FAIL %s halted: got %b want %b", tag, halted, m_halt); end
    total++;
    if (out_reg !== m_out) begin bad++; $display("FAIL %s out_reg: got %0h want %0h", tag, out_reg, m_out); end
    total++;
    if (out_valid !== m_ov) begin bad++; $display("FAIL %s out_valid: got %b want %b", tag, out_valid, m_ov); end
`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
    total++;
    if (retired_cnt !== 16'(m_ret)) begin bad++; $display("FAIL %s retired: got %0d want %0d", tag, retired_cnt, m_ret); end
`endif
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      total++;
      if (dbg_data !== m_r[i]) begin bad++; $display("FAIL %s R%0d: got %0h want %0h", tag, i, dbg_data, m_r[i]); end
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (pc !== 8'h00)     begin bad++; $display("FAIL rst pc: got %0h want 0", pc); end
    total++; if (state !== 3'd0)   begin bad++; $display("FAIL rst state: got %0d want 0", state); end
    total++; if (halted !== 1'b0)  begin bad++; $display("FAIL rst halted: got %b want 0", halted); end
    total++; if (out_reg !== 8'h00) begin bad++; $display("FAIL rst out_reg: got %0h want 0", out_reg); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
    total++; if (alu_a !== 8'h00)  begin bad++; $display("FAIL rst alu_a: got %0h want 0", alu_a); end
    total++; if (alu_b !== 8'h00)  begin bad++; $display("FAIL rst alu_b: got %0h want 0", alu_b); end
    total++; if (alu_sel !== 4'h0) begin bad++; $display("FAIL rst alu_sel: got %0h want 0", alu_sel); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      total++;
      if (dbg_data !== 8'h00) begin bad++; $display("FAIL rst R%0d: got %0h want 0", i, dbg_data); end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_hold state: got %0d want 0", state); end
  endtask

  task automatic test_program();
    fill_rom(8'hE0);
    rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h01; rom[3] = 8'hB0; rom[4] = 8'hF0;
    sw_a = 8'h05; sw_b = 8'h03;
    do_reset(1'b1);
    start_run();
    for (int i = 0; i < 5; i++) step_check("prog");
    total++; if (out_reg !== 8'h08) begin bad++; $display("FAIL prog final out: got %0h want 08", out_reg); end
    total++; if (pc !== 8'h04)      begin bad++; $display("FAIL prog final pc: got %0h want 04", pc); end
    total++; if (halted !== 1'b1)   begin bad++; $display("FAIL prog final halted: got %b want 1", halted); end
    dbg_sel = 2'd1;
    #1;
    total++; if (dbg_data !== 8'h03) begin bad++; $display("FAIL prog R1: got %0h want 03", dbg_data); end
`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
    total++; if (retired_cnt !== 16'd5) begin bad++; $display("FAIL prog retired: got %0d want 5", retired_cnt); end
`endif
    run = 1'b0;
    repeat (3) @(posedge clk);
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd5) begin bad++; $display("FAIL halt_hold state: got %0d want 5", state); end
    total++; if (pc !== 8'h04)   begin bad++; $display("FAIL halt_hold pc: got %0h want 04", pc); end
  endtask

  task automatic test_jmp();
    fill_rom(8'hE0);
    rom[0] = 8'hC7; rom[7] = 8'hF0;
    do_reset(1'b1);
    start_run();
    step_check("jmp");
    total++; if (pc !== 8'h07) begin bad++; $display("FAIL jmp target: got %0h want 07", pc); end
    step_check("jmp");
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (pc !== 8'h07 || halted !== 1'b1) begin bad++; $display("FAIL jmp halt: got pc=%0h halted=%b want 07/1", pc, halted); end
  endtask

  task automatic test_jz();
    fill_rom(8'hE0);
    rom[0] = 8'h94; rom[1] = 8'hD1; rom[8'h10] = 8'hF0;
    sw_a = 8'h10; sw_b = 8'h00;
    do_reset(1'b1);
    start_run();
    step_check("jz_taken");
    step_check("jz_taken");
    total++; if (pc !== 8'h10) begin bad++; $display("FAIL jz taken pc: got %0h want 10", pc); end
    step_check("jz_taken");
    fill_rom(8'hE0);
    rom[0] = 8'h94; rom[1] = 8'hA0; rom[2] = 8'hD1; rom[3] = 8'hF0;
    sw_a = 8'h10; sw_b = 8'h01;
    do_reset(1'b1);
    start_run();
    for (int i = 0; i < 3; i++) step_check("jz_not");
    total++; if (pc !== 8'h03) begin bad++; $display("FAIL jz not-taken pc: got %0h want 03", pc); end
    step_check("jz_not");
  endtask

  task automatic test_wrap();
    fill_rom(8'hE0);
    do_reset(1'b1);
    start_run();
    for (int i = 0; i < 255; i++) step_check("wrap");
    total++; if (pc !== 8'hFF) begin bad++; $display("FAIL wrap pre pc: got %0h want ff", pc); end
    step_check("wrap");
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL wrap post pc: got %0h want 00", pc); end
  endtask

  task automatic test_run_drop();
    fill_rom(8'hE0);
    rom[0] = 8'h98;
    sw_a = 8'($urandom_range(1, 255)); sw_b = 8'h00;
    do_reset(1'b1);
    start_run();
    model_step();
    @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL drop decode state: got %0d want 2", state); end
    run = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL drop idle state: got %0d want 0", state); end
    total++; if (pc !== 8'h01)   begin bad++; $display("FAIL drop pc: got %0h want 01", pc); end
    dbg_sel = 2'd2;
    #1;
    total++; if (dbg_data !== m_r[2]) begin bad++; $display("FAIL drop R2: got %0h want %0h", dbg_data, m_r[2]); end
    @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL drop hold state: got %0d want 0", state); end
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL drop resume state: got %0d want 1", state); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      fill_rom(8'hE0);
      rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h01; rom[3] = 8'hB0; rom[4] = 8'hF0;
      sw_a = 8'h05; sw_b = 8'h03;
      do_reset(1'b1);
      start_run();
      if (k == 0) begin
        for (int i = 0; i < 3; i++) step_check("rmid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL rmid exec state: got %0d want 3", state); end
      end else begin
        for (int i = 0; i < 5; i++) step_check("rhalt");
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++; if (pc !== 8'h00)       begin bad++; $display("FAIL rmid%0d pc: got %0h want 0", k, pc); end
      total++; if (state !== 3'd0)     begin bad++; $display("FAIL rmid%0d state: got %0d want 0", k, state); end
      total++; if (halted !== 1'b0)    begin bad++; $display("FAIL rmid%0d halted: got %b want 0", k, halted); end
      total++; if (out_reg !== 8'h00)  begin bad++; $display("FAIL rmid%0d out_reg: got %0h want 0", k, out_reg); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid%0d out_valid: got %b want 0", k, out_valid); end
      total++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 4'h0) begin
        bad++; $display("FAIL rmid%0d alu regs: got %0h/%0h/%0h want 0/0/0", k, alu_a, alu_b, alu_sel);
      end
`ifdef SEQ_CORE_CTRL_PERF_CNT_EN
      total++; if (retired_cnt !== 16'd0) begin bad++; $display("FAIL rmid%0d retired: got %0d want 0", k, retired_cnt); end
`endif
      for (int i = 0; i < 4; i++) begin
        dbg_sel = 2'(i);
        #1;
        total++;
        if (dbg_data !== 8'h00) begin bad++; $display("FAIL rmid%0d R%0d: got %0h want 0", k, i, dbg_data); end
      end
      reset = 1'b0;
      run = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) begin
        rom[a] = 8'($urandom);
        if (rom[a][7:4] == 4'hF && $urandom_range(0, 3) != 0) rom[a][7:4] = 4'($urandom_range(0, 14));
      end
      sw_a = 8'($urandom); sw_b = 8'($urandom);
      do_reset(1'b1);
      start_run();
      for (int n = 0; n < 60 && !m_halt; n++) begin
        sw_a = 8'($urandom);
        sw_b = 8'($urandom);
        step_check("rand");
      end
    end
  endtask

  initial begin
    sw_a = 8'h00; sw_b = 8'h00; dbg_sel = 2'd0;
    fill_rom(8'hE0);
    test_reset();
    test_program();
    test_jmp();
    test_jz();
    test_wrap();
    test_run_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
